// File: rtl/stream_demux.sv
`default_nettype none
// ============================================================================
//  Module   : stream_demux
//  Purpose  : Registered 1:N stream demultiplexer. Each input word is routed
//             to the output channel chosen by in_sel. Every channel has its
//             own one-entry output register with a valid/ready handshake.
//             A stalled channel only blocks words addressed to that channel.
//
//  Parameters:
//    DATA_W  - data word width
//    NUM_CH  - number of output channels (>= 2)
//    SEL_W   - derived width of in_sel, $clog2(NUM_CH); not overridable
//
//  Ports:
//    clk        in   1              rising-edge clock
//    rst_n      in   1              asynchronous active-low reset
//    in_valid   in   1              producer presents a word
//    in_ready   out  1              word accepted this cycle (combinational)
//    in_data    in   DATA_W         input word
//    in_sel     in   SEL_W          destination channel index
//    out_valid  out  NUM_CH         per-channel word-present flags
//    out_ready  in   NUM_CH         per-channel consumer accept
//    out_data   out  NUM_CH*DATA_W  channel i at [i*DATA_W +: DATA_W]
//    err        out  1              sticky out-of-range-select flag
//
//  Build option:
//    STREAM_DEMUX_ERR_EN - when defined, err latches on any accepted word
//                          whose in_sel is out of range. Otherwise err = 0.
//
//  Revision : 1.0 - initial release
// ============================================================================
module stream_demux #(
    parameter  int DATA_W = 8,
    parameter  int NUM_CH = 4,
    localparam int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [SEL_W-1:0]         in_sel,
    output logic [NUM_CH-1:0]        out_valid,
    input  logic [NUM_CH-1:0]        out_ready,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic                     err
);

    logic [NUM_CH-1:0]             r_vld;
    logic [NUM_CH-1:0][DATA_W-1:0] r_dat;

    logic [NUM_CH-1:0] w_hit;       // one-hot decode of in_sel
    logic [NUM_CH-1:0] w_ch_rdy;    // channel can take a word this cycle
    logic              w_sel_in_range;
    logic              w_xfer;

    // Out-of-range selects can only occur when NUM_CH is not a power of 2;
    // such words are always accepted and dropped so the producer never hangs.
    assign w_sel_in_range = (int'(in_sel) < NUM_CH);

    // Ready looks only at the addressed channel; the one-hot AND avoids a
    // variable index that could fall outside the channel range.
    assign in_ready = ~w_sel_in_range | (|(w_hit & w_ch_rdy));
    assign w_xfer   = in_valid & in_ready;

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            assign w_hit[i]    = (in_sel == SEL_W'(i));
            assign w_ch_rdy[i] = ~r_vld[i] | out_ready[i];

            // A load wins over a drain so that a simultaneous drain and load
            // keeps the channel full with the new word and no bubble.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_vld[i] <= 1'b0;
                    r_dat[i] <= '0;
                end else if (w_xfer && w_hit[i]) begin
                    r_vld[i] <= 1'b1;
                    r_dat[i] <= in_data;
                end else if (out_ready[i]) begin
                    r_vld[i] <= 1'b0;
                end
            end
        end
    endgenerate

    assign out_valid = r_vld;
    assign out_data  = r_dat;

`ifdef STREAM_DEMUX_ERR_EN
    logic r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_xfer && !w_sel_in_range) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/stream_demux.md
Name: stream_demux

Overview:
- Parametrised, registered 1:N demultiplexer with valid/ready handshakes on the input and on every output channel.
- Routes each input word to the output channel selected by in_sel.
- Each channel holds the word in a one-entry output register until the consumer accepts it.
- Generalises the combinational 1:4 demux to any width and channel count, adding backpressure and per-channel buffering.
- Sits between a single producer and N independent consumers in the datapath.

Parameters:
- DATA_W, 8, width of the data word.
- NUM_CH, 4, number of output channels; legal range is 2 or more.
- SEL_W, derived localparam = $clog2(NUM_CH), width of in_sel; not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  producer presents a word.
- in_ready  output  1  block accepts a word this cycle (combinational).
- in_data  input  DATA_W  input word.
- in_sel  input  SEL_W  destination channel index.
- out_valid  output  NUM_CH  per-channel word-present flag; bit i is channel i.
- out_ready  input  NUM_CH  per-channel consumer accept.
- out_data  output  NUM_CH*DATA_W  packed channel words; channel i occupies bits [i*DATA_W +: DATA_W].
- err  output  1  sticky out-of-range-select flag; see Optional Feature.

Behaviour:
- Clocking and reset: one clock domain (clk); rst_n is asynchronous, active-low.
- Reset values: out_valid = 0, every out_data slice = 0, err = 0. All three are forced immediately on rst_n assertion, including mid-transfer; buffered words are discarded.
- Channel register: each channel i has a register pair {vld_i, dat_i} driving out_valid[i] and its out_data slice.
- in_ready, in-range sel: in_ready = ~out_valid[in_sel] | out_ready[in_sel]. It depends only on the selected channel, so a stalled channel never blocks traffic to other channels.
- in_ready, out-of-range sel (in_sel >= NUM_CH, possible only when NUM_CH is not a power of 2): in_ready = 1.
- Input transfer: occurs on a clock edge where in_valid && in_ready.
- Output transfer on channel i: occurs on a clock edge where out_valid[i] && out_ready[i].
- Per-channel update at each clock edge, in priority order:
  1. Input transfer with in_sel == i: dat_i <= in_data, vld_i <= 1. This also covers a simultaneous drain; the new word replaces the drained one with no bubble.
  2. Otherwise, output transfer on i: vld_i <= 0; dat_i holds its last value.
  3. Otherwise: hold.
- Latency: a word accepted at edge k is visible on out_valid/out_data of its channel after edge k, i.e. one cycle.
- Throughput: one word per cycle to any channel whose consumer keeps out_ready high.
- Out-of-range select: the word is accepted and dropped; no channel changes.
- out_ready on a channel with out_valid = 0 has no effect.
- Source rule (checked by the bench, not enforced by RTL): while in_valid && !in_ready, in_data and in_sel stay stable.
- Output stability: while out_valid[i] && !out_ready[i], that channel's data slice stays stable.
- Parallel drains: multiple channels may drain in the same cycle independently.
- No combinational path exists from in_valid to in_ready or from in_* to out_*. The only combinational path is out_ready/in_sel -> in_ready.

Optional Feature:
- Macro: STREAM_DEMUX_ERR_EN.
- Defined: err sets to 1 on any accepted out-of-range transfer and stays 1 until rst_n asserts. It does not gate in_ready.
- Not defined: err is tied to 0 and out-of-range words are still accepted and silently dropped.
- With NUM_CH a power of 2, err is 0 in both builds.

Test Plan:
- Reset: assert rst_n = 0 mid-stream with out_valid = 4'b0101 -> out_valid = 0, all out_data slices = 0, err = 0 immediately, before any clock edge.
- Basic routing (DATA_W = 8, NUM_CH = 4, all out_ready = 1): send in_data = 8'hA0..8'hA3 with in_sel = 0..3 on consecutive cycles -> out_valid[i] pulses one cycle after acceptance with slice i = 8'hA0 + i; in_ready stays 1 throughout.
- Backpressure isolation: out_ready[2] = 0, send 8'h55 to channel 2, then 8'h66 to channel 2 -> second word stalls with in_ready = 0 and channel 2 holds 8'h55. A following 8'h77 to channel 1 is accepted and sent after the stall is released.
- Simultaneous drain and load: channel 3 holds 8'h11, out_ready[3] = 1, in_valid with in_sel = 3 and in_data = 8'h22 in the same cycle -> in_ready = 1, out_valid[3] stays 1, slice 3 = 8'h22 next cycle, no bubble.
- Out-of-range select (NUM_CH = 3, macro defined): in_sel = 2'd3, in_data = 8'hFF -> in_ready = 1, out_valid unchanged, err = 1 after the edge and still 1 ten cycles later. Macro undefined: err stays 0.
- Random soak: 2000 cycles of random in_valid/in_sel/out_ready -> scoreboard shows per-channel in-order delivery, no loss or duplication, and output stability under stall.
